div_seq: RTL and testbench

Iterative 32-bit divider sequencer serving the EX stage for DIV/DIVU. EX raises a start request with operands and holds it; the block runs a shift-subtract divide over 32 cycles, then presents a 64-bit {remainder, quotient} result for HI/LO writeback. While the divide is in progress, EX converts the pending request into a pipeline stall request. Annulment (flush, exception) aborts an in-flight divide.

---
 rtl/div_seq.sv | 138 +++++++++++++
 tb/tb_div_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Iterative 32-bit restoring divider for DIV/DIVU. Accepts a held start request,
// runs 32 shift-subtract iterations and presents {remainder, quotient} until start drops.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  // Handshake: start_i is held by the requester until it has seen ready_o; the
  // result stays valid (ready_o=1) for as long as start_i remains high.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        signed_q, signed_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [64:0] shifted;
  logic [32:0] trial;
  logic        trial_ok;
  logic [31:0] abs_op1, abs_op2;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    shifted  = {work_q[63:0], 1'b0};
    trial    = shifted[64:32] - {1'b0, divisor_q};
    trial_ok = (shifted[64:32] >= {1'b0, divisor_q});
    abs_op1  = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    abs_op2  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    quo_fix  = (signed_q && neg_quo_q) ? (~work_q[31:0] + 32'd1) : work_q[31:0];
    rem_fix  = (signed_q && neg_rem_q) ? (~work_q[63:32] + 32'd1) : work_q[63:32];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    signed_d  = signed_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          signed_d  = signed_div_i;
          divisor_d = abs_op2;
          work_d    = {33'd0, abs_op1};
          cnt_d     = 6'd0;
          neg_quo_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
          neg_rem_d = signed_div_i & opdata1_i[31];
          state_d   = (opdata2_i == 32'd0) ? BYZERO : RUN;
        end
      end
      BYZERO: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          state_d  = DONE;
          result_d = 64'd0;
          ready_d  = 1'b1;
        end
      end
      RUN: begin
        if (annul_i) begin
          state_d = IDLE;
        end else if (cnt_q == 6'd32) begin
          state_d  = DONE;
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
        end else begin
          // Quotient bits enter at the LSB as the dividend shifts out the top.
          work_d = trial_ok ? {trial, shifted[31:1], 1'b1} : shifted;
          cnt_d  = cnt_q + 6'd1;
        end
      end
      DONE: begin
        if (!start_i) begin
          state_d  = IDLE;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      work_q    <= 65'd0;
      divisor_q <= 32'd0;
      signed_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q == BYZERO) || (state_q == RUN);

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: hand-computed divide results, latency, annul,
// reset and start-hold behaviour.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  logic [63:0] exp_q[$];
  int          n_checks;
  int          n_errors;

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request and wait for ready_o; inputs are set 1ns after an edge.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input int exp_lat, input bit scramble);
    int cyc;
    int busy_cnt;
    logic [63:0] e;
    exp_q.push_back(exp_res);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();
    busy_cnt = busy_o ? 1 : 0;
    cyc      = 0;
    while (!ready_o && cyc < 40) begin
      if (scramble && cyc == 5) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom_range(32'hFFFF_FFFF, 1);
        signed_div_i = ~sgn;
      end
      tick();
      cyc++;
      if (busy_o) busy_cnt++;
    end
    e = exp_q.pop_front();
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check({tag, "_ready"}, 64'(ready_o), 64'd1);
    check({tag, "_result"}, result_o, e);
  endtask

  task automatic release_start(input string tag);
    start_i = 1'b0;
    tick();
    check({tag, "_rel_ready"}, 64'(ready_o), 64'd0);
    check({tag, "_rel_result"}, result_o, 64'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    tick();
    tick();
    check("reset_result", result_o, 64'd0);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    rst = 1'b0;
    tick();

    // Basic unsigned and signed divides
    run_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b0);
    release_start("u100_7");
    run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
    release_start("s_m7_2");
    run_div("u_fff9_2", 1'b0, 32'hFFFFFFF9, 32'h2, 64'h00000001_7FFFFFFC, 33, 1'b0);
    release_start("u_fff9_2");
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 1'b0);
    release_start("s_7_m2");
    run_div("s_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33, 1'b0);
    release_start("s_m100_m7");
    run_div("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33, 1'b0);
    release_start("u_max_1");
    run_div("u_5_max", 1'b0, 32'd5, 32'hFFFFFFFF, 64'h00000005_00000000, 33, 1'b0);
    release_start("u_5_max");

    // Divide by zero
    run_div("byzero", 1'b0, 32'h1234, 32'd0, 64'd0, 1, 1'b0);
    release_start("byzero");

    // Overflow wrap, with operands scrambled mid-run
    run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 1'b1);
    release_start("s_min_m1");

    // start with annul in IDLE is ignored
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd5;
    start_i      = 1'b1;
    annul_i      = 1'b1;
    tick();
    check("idle_annul_busy", 64'(busy_o), 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();

    // Annul at the 10th RUN cycle, then an immediate new request
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) tick();
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    check("annul_busy", 64'(busy_o), 64'd0);
    check("annul_ready", 64'(ready_o), 64'd0);
    run_div("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1'b0);
    release_start("u9_3");

    // Annul coinciding with the DONE transition wins
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) tick();
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    check("late_annul_ready", 64'(ready_o), 64'd0);
    check("late_annul_busy", 64'(busy_o), 64'd0);
    start_i = 1'b0;
    tick();

    // Reset in the middle of a run
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    start_i = 1'b0;
    check("mid_rst_result", result_o, 64'd0);
    check("mid_rst_ready", 64'(ready_o), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    tick();
    check("post_rst_busy", 64'(busy_o), 64'd0);

    // Start held through DONE with new operands: no restart, annul ignored
    run_div("hold_a", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b0);
    opdata1_i = 32'd1000;
    opdata2_i = 32'd10;
    tick();
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    tick();
    check("hold_ready", 64'(ready_o), 64'd1);
    check("hold_busy", 64'(busy_o), 64'd0);
    check("hold_result", result_o, 64'h00000002_0000000E);
    release_start("hold_a");
    run_div("hold_b", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 33, 1'b0);
    release_start("hold_b");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
